// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle instruction sequencer for the MIPS core.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, handshakes
// with instruction/data memory under a bounded wait, counts retired legal
// instructions and keeps sticky Illegal/Timeout flags.
module mips_mc_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Run,
    input  logic [31:0]      Ins,
    input  logic             Imem_ack,
    input  logic             Dmem_ack,
    output logic             Imem_req,
    output logic             IR_we,
    output logic             EX_we,
    output logic             Dmem_re,
    output logic             Dmem_we,
    output logic             RF_we,
    output logic             PC_we,
    output logic             Illegal,
    output logic             Timeout,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // C_ALU covers every class that ends in a register write-back (ALU-R,
    // ALU-I, JAL); C_BR covers branches/jumps and JR, which finish in EXEC.
    typedef enum logic [2:0] {
        C_ILL = 3'd0,
        C_ALU = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BR  = 3'd4
    } cls_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    cls_t             dec_cls;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       wait_inc;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             boundary;
    logic             retire;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             unused_ins;

    // Instruction classification from opcode and funct fields.
    always_comb begin
        op         = Ins[31:26];
        funct      = Ins[5:0];
        unused_ins = ^Ins[25:6];
        dec_cls    = C_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: dec_cls = C_ALU;
                    6'h08:        dec_cls = C_BR;
                    default:      dec_cls = C_ILL;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_cls = C_ALU;
            6'h03:                      dec_cls = C_ALU;
            6'h23:                      dec_cls = C_LW;
            6'h2B:                      dec_cls = C_SW;
            6'h02, 6'h04, 6'h05:        dec_cls = C_BR;
            default:                    dec_cls = C_ILL;
        endcase
    end

    // Next-state, wait counter, sticky flags and retire decision.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        boundary  = 1'b0;
        retire    = 1'b0;
        wait_inc  = wait_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (Imem_ack) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_inc == LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL) begin
                    illegal_d = 1'b1;
                    boundary  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    C_ALU: state_d = S_WB;
                    default: begin
                        boundary = 1'b1;
                        retire   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (Dmem_ack) begin
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        boundary = 1'b1;
                        retire   = 1'b1;
                    end
                end else if (wait_inc == LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB: begin
                boundary = 1'b1;
                retire   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (boundary) begin
            state_d = Run ? S_FETCH : S_IDLE;
            wait_d  = '0;
        end
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Sequencer registers; reset returns to IDLE and clears every counter/flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ILL;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes: state-decoded, with IR_we and PC_we also qualified by ack/class.
    always_comb begin
        Imem_req = (state_q == S_FETCH);
        IR_we    = (state_q == S_FETCH) && Imem_ack;
        EX_we    = (state_q == S_EXEC);
        Dmem_re  = (state_q == S_MEM) && (cls_q == C_LW);
        Dmem_we  = (state_q == S_MEM) && (cls_q == C_SW);
        RF_we    = (state_q == S_WB);
        PC_we    = boundary;
        Illegal  = illegal_q;
        Timeout  = timeout_q;
        State    = state_q;
        Retired  = retired_q;
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed literal checks followed by randomized stimulus
// compared every cycle against a plan-based behavioural model.
module tb_mips_mc_ctrl;

    localparam int CNT_W      = 4;
    localparam int WAIT_LIMIT = 16;
    localparam int MASK       = (1 << CNT_W) - 1;
    // Architectural State codes.
    localparam int SI = 0, SF = 1, SD = 2, SE = 3, SM = 4, SB = 5;

    logic             CLK = 1'b0;
    logic             RST, Run, Imem_ack, Dmem_ack;
    logic [31:0]      Ins;
    logic             Imem_req, IR_we, EX_we, Dmem_re, Dmem_we, RF_we, PC_we;
    logic             Illegal, Timeout;
    logic [2:0]       State;
    logic [CNT_W-1:0] Retired;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .CLK(CLK), .RST(RST), .Run(Run), .Ins(Ins),
        .Imem_ack(Imem_ack), .Dmem_ack(Dmem_ack),
        .Imem_req(Imem_req), .IR_we(IR_we), .EX_we(EX_we),
        .Dmem_re(Dmem_re), .Dmem_we(Dmem_we), .RF_we(RF_we), .PC_we(PC_we),
        .Illegal(Illegal), .Timeout(Timeout), .State(State), .Retired(Retired)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 illegal, 1 ends in write-back, 2 load, 3 store, 4 finishes in EXEC
    function automatic int classify(input logic [31:0] ins);
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0) begin
            if (fn == 8) return 4;
            if (fn inside {0, 2, 3, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B}) return 1;
            return 0;
        end
        if (op inside {[8:15]} || op == 3) return 1;
        if (op == 'h23) return 2;
        if (op == 'h2B) return 3;
        if (op inside {2, 4, 5}) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [5:0]  fns [13];
        logic [5:0]  brs [3];
        fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        brs = '{6'h02, 6'h04, 6'h05};
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 12)]; end
            2:    begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            3:    r[31:26] = 6'($urandom_range(8, 15));
            4:    r[31:26] = 6'h23;
            5:    r[31:26] = 6'h2B;
            6:    r[31:26] = brs[$urandom_range(0, 2)];
            7:    r[31:26] = 6'h03;
            8:    r[31:26] = 6'h00;
            default: ;
        endcase
        return r;
    endfunction

    // Model: the remaining stages of the current instruction, front = now.
    int plan[$];
    int m_wait = 0;
    int m_ret  = 0;
    bit m_ill  = 0;
    bit m_to   = 0;
    bit m_lw   = 0;

    always @(negedge CLK) begin : cmp
        int cur, c;
        bit ack, adv, fin;
        if (RST) begin
            chk("reset_strobes", 32'({Imem_req, IR_we, EX_we, Dmem_re, Dmem_we, RF_we, PC_we,
                                      Illegal, Timeout, State}), 32'd0);
            chk("reset_Retired", 32'(Retired), 32'd0);
            plan.delete();
            m_wait = 0; m_ret = 0; m_ill = 0; m_to = 0; m_lw = 0;
        end else begin
            cur = (plan.size() != 0) ? plan[0] : SI;
            chk("State",   32'(State),   32'(cur));
            chk("Illegal", 32'(Illegal), 32'(m_ill));
            chk("Timeout", 32'(Timeout), 32'(m_to));
            chk("Retired", 32'(Retired), 32'(m_ret));
            if (cur == SD) begin
                c = classify(Ins);
                m_lw = (c == 2);
                if (c != 0) plan.push_back(SE);
                if (c == 2 || c == 3) plan.push_back(SM);
                if (c == 1 || c == 2) plan.push_back(SB);
            end
            ack = (cur == SF && Imem_ack) || (cur == SM && Dmem_ack);
            adv = !(cur == SF || cur == SM) || ack;
            fin = (cur != SI) && (plan.size() == 1) && adv;
            chk("Imem_req", 32'(Imem_req), 32'(cur == SF));
            chk("IR_we",    32'(IR_we),    32'(cur == SF && Imem_ack));
            chk("EX_we",    32'(EX_we),    32'(cur == SE));
            chk("Dmem_re",  32'(Dmem_re),  32'(cur == SM && m_lw));
            chk("Dmem_we",  32'(Dmem_we),  32'(cur == SM && !m_lw));
            chk("RF_we",    32'(RF_we),    32'(cur == SB));
            chk("PC_we",    32'(PC_we),    32'(fin));
            if (cur == SD && plan.size() == 1) m_ill = 1;
            if (cur == SI) begin
                if (Run) begin plan = '{SF, SD}; m_wait = 0; end
            end else if (!adv) begin
                m_wait++;
                if (m_wait == WAIT_LIMIT) begin m_to = 1; plan.delete(); end
            end else begin
                void'(plan.pop_front());
                m_wait = 0;
                if (fin) begin
                    if (cur != SD) m_ret = (m_ret + 1) & MASK;
                    if (Run) plan = '{SF, SD};
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    initial begin
        int add_seq [5];
        int lw_seq [7];
        int nre, nreq, nir;
        bit stall;
        add_seq = '{1, 2, 3, 5, 1};
        lw_seq  = '{2, 3, 4, 4, 4, 4, 5};

        RST = 1'b1; Run = 1'b0; Imem_ack = 1'b0; Dmem_ack = 1'b0; Ins = '0;
        tick(); tick();
        samp();
        chk("lit_rst_State", 32'(State), 32'd0);
        chk("lit_rst_Retired", 32'(Retired), 32'd0);

        // ADD back-to-back with immediate acks, then a LW in the following slot
        tick(); RST = 1'b0; Run = 1'b1; Imem_ack = 1'b1; Dmem_ack = 1'b1; Ins = 32'h0000_0020;
        samp();
        chk("lit_add_idle", 32'(State), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) begin Ins = 32'h8C00_0000; Dmem_ack = 1'b0; end
            samp();
            chk("lit_add_state", 32'(State), 32'(add_seq[i]));
            if (i == 2) chk("lit_add_EX_we", 32'(EX_we), 32'd1);
            if (i == 3) chk("lit_add_wb", 32'({RF_we, PC_we}), 32'd3);
            if (i == 4) chk("lit_add_Retired", 32'(Retired), 32'd1);
        end

        // LW with Dmem_ack arriving on the fourth MEM cycle
        nre = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            Dmem_ack = (k == 5);
            if (k == 6) Run = 1'b0;
            samp();
            chk("lit_lw_state", 32'(State), 32'(lw_seq[k]));
            if (Dmem_re) nre++;
            if (k == 6) chk("lit_lw_wb", 32'({RF_we, PC_we}), 32'd3);
        end
        chk("lit_lw_re_cycles", 32'(nre), 32'd4);
        tick(); samp();
        chk("lit_lw_idle", 32'(State), 32'd0);
        chk("lit_lw_Retired", 32'(Retired), 32'd2);

        // Undefined opcode: PC_we in DECODE, sticky Illegal, Retired unchanged
        tick(); Run = 1'b1; samp();
        tick(); Run = 1'b0; Ins = 32'hFC00_0000; samp();
        chk("lit_ill_fetch", 32'(State), 32'd1);
        tick(); samp();
        chk("lit_ill_decode", 32'({State, PC_we, Illegal}), 32'b010_1_0);
        tick(); samp();
        chk("lit_ill_after", 32'({State, Illegal}), 32'b000_1);
        chk("lit_ill_Retired", 32'(Retired), 32'd2);

        // Fetch timeout: no ack for WAIT_LIMIT cycles
        tick(); Run = 1'b1; Imem_ack = 1'b0; samp();
        nreq = 0; nir = 0;
        for (int t = 0; t < 40; t++) begin
            tick(); Run = 1'b0; samp();
            if (Imem_req) nreq++;
            if (IR_we) nir++;
            if (State == 3'd0) break;
        end
        chk("lit_to_req_cycles", 32'(nreq), 32'(WAIT_LIMIT));
        chk("lit_to_ir_we", 32'(nir), 32'd0);
        chk("lit_to_end", 32'({State, Imem_req, Timeout, Illegal}), 32'b000_0_1_1);

        // Randomized phase
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        stall = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            tick();
            if ($urandom_range(0, 99) == 0) stall = !stall;
            RST      = ($urandom_range(0, 399) == 0);
            Run      = ($urandom_range(0, 7) != 0);
            Imem_ack = stall ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) != 0);
            Dmem_ack = stall ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) != 0);
            if (plan.size() == 0 || plan[0] == SF) Ins = rand_ins();
        end
        tick(); RST = 1'b0; samp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the IF instruction-register load, the EX result/newPC latch, data-memory strobes, register-file write and PC write.
- Handshakes with instruction and data memory (req/ack with timeout). Keeps a retired-instruction counter and sticky error flags.

Parameters:
- CNT_W, 32, width of Retired counter.
- WAIT_LIMIT, 16, max cycles a memory request may wait for ack before timeout (range 1..255).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Run  in  1  enable sequencing; sampled only when an instruction boundary is reached.
- Ins  in  32  instruction register contents; valid from DECODE onward.
- Imem_ack  in  1  instruction memory data valid.
- Dmem_ack  in  1  data memory access complete.
- Imem_req  out  1  instruction fetch request.
- IR_we  out  1  load instruction register.
- EX_we  out  1  latch EX Result/newPC.
- Dmem_re  out  1  data read request (lw).
- Dmem_we  out  1  data write request (sw).
- RF_we  out  1  register file write.
- PC_we  out  1  PC update, exactly one pulse per completed or skipped instruction.
- Illegal  out  1  sticky: undefined opcode/funct decoded.
- Timeout  out  1  sticky: memory ack not received within WAIT_LIMIT.
- State  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Retired  out  CNT_W  count of retired legal instructions.

Behaviour:
- RST=1 (async): State=IDLE; all outputs 0, including Retired, Illegal, Timeout and the wait counter.
- Imem_req, Dmem_re, Dmem_we, RF_we and EX_we are decoded from State (Moore). IR_we and the MEM-state PC_we are also qualified by ack (Mealy).
- "Boundary" means the next state is FETCH if Run=1, otherwise IDLE.
- Run=0 mid-instruction does not abort; the instruction completes.
- IDLE: all strobes 0. Run=1 → FETCH next cycle.
- FETCH: Imem_req=1.
  - Imem_ack=1: IR_we=1 that cycle, → DECODE.
  - Imem_ack=0: stay.
- DECODE (1 cycle): classify Ins[31:26]/Ins[5:0].
  - ALU-R: op 0x00, funct ∈ {00,02,03,20,21,22,23,24,25,26,27,2A,2B}.
  - JR: op 0x00, funct 0x08.
  - ALU-I: op 0x08–0x0F.
  - LW: 0x23. SW: 0x2B.
  - BR: 0x04, 0x05, 0x02. JAL: 0x03.
  - Anything else: Illegal←1, PC_we=1, Retired unchanged, → boundary. All legal classes → EXEC.
- EXEC (1 cycle): EX_we=1.
  - LW/SW → MEM.
  - ALU-R, ALU-I, JAL → WB.
  - BR, JR: PC_we=1, Retired+1, → boundary.
- MEM: Dmem_re=1 (LW) or Dmem_we=1 (SW).
  - On Dmem_ack, LW → WB.
  - On Dmem_ack, SW: PC_we=1, Retired+1, → boundary.
- WB (1 cycle): RF_we=1, PC_we=1, Retired+1, → boundary.
- Latency with immediate acks, back-to-back:
  - BR/JR: 3 cycles.
  - ALU/JAL: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH/MEM.
  - Increments each FETCH/MEM cycle without ack.
  - Ack is accepted in any cycle the request is high, including the first.
  - When the count reaches WAIT_LIMIT with no ack: Timeout←1, request dropped, → IDLE. No PC_we, IR_we or RF_we is issued.
  - Acks arriving while the corresponding request is low are ignored.
- Retired wraps from 2^CNT_W−1 to 0 without a flag.
- Illegal and Timeout clear only on RST.
- RST asserted mid-MEM or mid-WB: strobes drop immediately (async). No partial RF_we or PC_we is issued after reset release.

Test Plan:
- ADD (Ins=0x00000020) with Run=1 and acks tied 1 → State sequence 1,2,3,5,1. EX_we then RF_we+PC_we pulses, 4 cycles apart per instruction; Retired=1.
- LW (0x8C000000), Dmem_ack delayed 3 cycles → Dmem_re high 4 cycles, then WB with RF_we=1. Retired increments once; 8 cycles total.
- SW (0xAC000000) followed by BEQ (0x10000000) → SW: Dmem_we then PC_we with no RF_we. BEQ: PC_we in EXEC, 3 cycles. Retired=2.
- Ins=0xFC000000 → Illegal=1 and PC_we pulse in DECODE. Retired unchanged; next FETCH proceeds; Illegal remains 1.
- Imem_ack held 0, WAIT_LIMIT=16 → Timeout=1 after 16 FETCH cycles, Imem_req=0, State=0, no IR_we.
- Run dropped during EXEC of ADDI (0x20000003) → completes WB, then State=0. RST pulse mid-MEM → all outputs 0 immediately; Retired=0.
